muldiv_ctrl: RTL
================

# muldiv_ctrl

Sequencer for the HI/LO multiply/divide resource of the 5-stage MIPS pipeline. It sits beside the execute stage and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from E. Multiplies run over a fixed count of cycles; divides run through an iterative restoring divider. While busy, it raises a stall that the hazard unit ORs into its pipeline stall, but only when the instruction in E touches HI/LO. Unrelated instructions keep flowing under a long divide.

## Interface
Parameters:
- MUL_CYCLES, default 4: cycles from multiply accept to HI/LO write (legal range 1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- validE  in  1  instruction in E is valid and not being flushed.
- opE  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; 9..15 treated as NONE.
- vaE  in  32  forwarded rs value (dividend, multiplicand, MT source).
- vbE  in  32  forwarded rt value (divisor, multiplier).
- cancel  in  1  abort the in-flight operation (the exception hit its issuing instruction).
- hi, lo  out  32  architectural HI/LO registers.
- rdataE  out  32  MFHI → hi, MFLO → lo, otherwise 0; combinational.
- busy  out  1  a multiply or divide is in flight.
- stall  out  1  freeze F/D/E this cycle.

## Operation
- State machine has four states: IDLE, MUL, DIV, FIX.
- hilo_op = validE & opE ∈ {1..8}.
- stall = busy & hilo_op. This is combinational; there is no stall in IDLE.
- Start: in IDLE with validE, no cancel, and opE ∈ {1..4}:
  - Latch the operands and signedness.
  - Load the counter.
  - Go to MUL (opE 1, 2) or DIV (opE 3, 4).
  - The issuing instruction is not stalled.
- MTHI/MTLO: in IDLE with validE, write hi or lo from vaE at the edge. Blocked by stall while busy.
- MUL state:
  - Counter loads MUL_CYCLES−1 and decrements.
  - At counter 0, write {hi,lo} = 64-bit product (signed for MULT, unsigned for MULTU) and return to IDLE.
- DIV state:
  - Operate on 32 iterations on magnitudes (absolute values for DIV, raw values for DIVU).
  - Each iteration shifts one dividend bit into a 33-bit partial remainder, subtracts the divisor, and keeps the result if it is non-negative.
  - Counter loads 31; after the iteration at counter 0, go to FIX.
- FIX state (one cycle):
  - Negate the quotient if the operand signs differ (DIV only).
  - Negate the remainder if the dividend is negative (DIV only).
  - Write lo = quotient, hi = remainder, then return to IDLE.
  - Result: quotient truncates toward zero; remainder takes the dividend's sign.
- Divisor 0, both signed and unsigned: lo = 0xFFFFFFFF, hi = dividend. Special-cased; no exception.
- DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- cancel:
  - In any non-IDLE state, go to IDLE at the next edge; hi/lo are unchanged.
  - A start or MT in the same cycle is ignored.
  - In IDLE, cancel only suppresses that cycle's start or MT.
- reset: state IDLE, counter 0, hi = lo = 0, busy = 0, hence stall = 0. Reset overrides every other input.

## Timing
- Accepting edge T.
- Multiply:
  - busy is high for cycles T+1 .. T+MUL_CYCLES.
  - hi/lo are updated at the end of cycle T+MUL_CYCLES.
  - An MFHI in E during cycle T+MUL_CYCLES+1 reads the new value with no stall.
- Divide:
  - busy is high for cycles T+1 .. T+33 (32 iterations plus FIX).
  - hi/lo are updated at the end of cycle T+33.
- busy = (state ≠ IDLE). In the final busy cycle, an MF/MT/muldiv in E is still stalled; the result is not bypassed.
- A back-to-back muldiv is accepted at the first edge after busy falls.
- rdataE always reflects the registered hi/lo; a write lands at the edge.

## Configuration
- MULDIV_FASTDIV_EN:
  - Defined:
    - Divisor 0, or |dividend| < |divisor| (unsigned compare of magnitudes), skips DIV and goes straight to FIX.
    - The result is quotient 0 and remainder = dividend (divisor-0 case as specified above).
    - busy is high for 1 cycle only.
  - Undefined: every divide takes the full 33 busy cycles.
  - Results are identical in both builds.

## Test plan
- Reset asserted for 2 cycles with opE = MULT, validE = 1 → hi = lo = 0, busy = 0, stall = 0 throughout; no start.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF with MUL_CYCLES = 4, then MFHI in E the next cycle:
  - stall high for 4 cycles (T+1..T+4).
  - Then rdataE = 0xFFFFFFFE, and lo = 0x00000001.
- DIV 0xFFFFFFF9 (−7) / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF after exactly 33 busy cycles.
- In the same run, an ADD in E during busy → stall = 0.
- DIVU 0x12345678 / 0 → lo = 0xFFFFFFFF, hi = 0x12345678. busy lasts 33 cycles without the macro and 1 cycle with MULDIV_FASTDIV_EN.
- DIV started, then cancel at busy cycle 10 → busy = 0 at the next cycle; hi/lo keep their prior values (preload them via MTHI 0xAAAA0000 / MTLO 0x5555).
- MTLO 0xDEADBEEF in E while a multiply is busy:
  - stall holds it.
  - lo = product lo at completion, then 0xDEADBEEF one edge after busy falls.

Source files
------------

// File: rtl/muldiv_if.sv
// HI/LO multiply/divide request and result bundle between the execute stage and muldiv_ctrl.
interface muldiv_if;
    logic        validE;
    logic [3:0]  opE;
    logic [31:0] vaE;
    logic [31:0] vbE;
    logic        cancel;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rdataE;
    logic        busy;
    logic        stall;

    modport master (
        output validE, opE, vaE, vbE, cancel,
        input  hi, lo, rdataE, busy, stall
    );

    modport slave (
        input  validE, opE, vaE, vbE, cancel,
        output hi, lo, rdataE, busy, stall
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: fixed-latency multiply, 32-step restoring divide.
// Optional MULDIV_FASTDIV_EN skips the iterations when the quotient is trivially zero.
module muldiv_ctrl #(
    parameter int unsigned MUL_CYCLES = 4
) (
    input logic     clk,
    input logic     reset,
    muldiv_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMthi  = 4'd5;
    localparam logic [3:0] OpMtlo  = 4'd6;
    localparam logic [3:0] OpMfhi  = 4'd7;
    localparam logic [3:0] OpMflo  = 4'd8;
    localparam logic [4:0] MulCnt  = 5'(MUL_CYCLES - 1);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] quo_q, quo_d, rem_q, rem_d;
    logic        signed_q, signed_d, qneg_q, qneg_d, rneg_q, rneg_d, div0_q, div0_d;

    logic        hilo_op, busy, a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_fix, r_fix;
    logic [32:0] shifted, diff;
    logic [63:0] ext_a, ext_b, prod;
`ifdef MULDIV_FASTDIV_EN
    logic        fast_skip;
`endif

    always_comb begin
        hilo_op = bus.validE && (bus.opE != 4'd0) && (bus.opE <= OpMflo);
        busy    = (state_q != StIdle);
        a_neg   = (bus.opE == OpDiv) && bus.vaE[31];
        b_neg   = (bus.opE == OpDiv) && bus.vbE[31];
        a_mag   = a_neg ? -bus.vaE : bus.vaE;
        b_mag   = b_neg ? -bus.vbE : bus.vbE;
`ifdef MULDIV_FASTDIV_EN
        fast_skip = (bus.vbE == 32'd0) || (a_mag < b_mag);
`endif
        // Sign-extend before a 64x64 multiply so the low 64 bits are the signed product.
        ext_a   = signed_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        ext_b   = signed_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        prod    = ext_a * ext_b;
        shifted = {rem_q, quo_q[31]};
        diff    = shifted - {1'b0, b_q};
        q_fix   = qneg_q ? -quo_q : quo_q;
        r_fix   = rneg_q ? -rem_q : rem_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        a_d      = a_q;
        b_d      = b_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        signed_d = signed_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        div0_d   = div0_q;
        unique case (state_q)
            StIdle: begin
                if (bus.validE && !bus.cancel) begin
                    case (bus.opE)
                        OpMult, OpMultu: begin
                            state_d  = StMul;
                            cnt_d    = MulCnt;
                            a_d      = bus.vaE;
                            b_d      = bus.vbE;
                            signed_d = (bus.opE == OpMult);
                        end
                        OpDiv, OpDivu: begin
                            state_d = StDiv;
                            cnt_d   = 5'd31;
                            b_d     = b_mag;
                            quo_d   = a_mag;
                            rem_d   = 32'd0;
                            qneg_d  = a_neg ^ b_neg;
                            rneg_d  = a_neg;
                            div0_d  = (bus.vbE == 32'd0);
`ifdef MULDIV_FASTDIV_EN
                            if (fast_skip) begin
                                state_d = StFix;
                                quo_d   = 32'd0;
                                rem_d   = a_mag;
                            end
`endif
                        end
                        OpMthi:  hi_d = bus.vaE;
                        OpMtlo:  lo_d = bus.vaE;
                        default: ;
                    endcase
                end
            end
            StMul: begin
                if (cnt_q == 5'd0) begin
                    {hi_d, lo_d} = prod;
                    state_d      = StIdle;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            StDiv: begin
                // A set borrow bit means the trial subtraction went negative: restore.
                rem_d = diff[32] ? shifted[31:0] : diff[31:0];
                quo_d = {quo_q[30:0], ~diff[32]};
                if (cnt_q == 5'd0) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            StFix: begin
                hi_d    = r_fix;
                lo_d    = div0_q ? 32'hFFFF_FFFF : q_fix;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (bus.cancel && busy) begin
            state_d = StIdle;
            cnt_d   = 5'd0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= 5'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            quo_q    <= 32'd0;
            rem_q    <= 32'd0;
            signed_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            a_q      <= a_d;
            b_q      <= b_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            signed_q <= signed_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            div0_q   <= div0_d;
        end
    end

    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;
    assign bus.busy   = busy;
    assign bus.stall  = busy && hilo_op;
    assign bus.rdataE = (bus.opE == OpMfhi) ? hi_q :
                        (bus.opE == OpMflo) ? lo_q : 32'd0;

endmodule
